// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, FIFO geometry, LCR field layout.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned FIFO_AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CW    = FIFO_AW + 1;
    localparam int unsigned FIFO_W     = 11;

    // LCR bit positions
    localparam int unsigned LCR_WLS_LSB = 0;
    localparam int unsigned LCR_PEN     = 3;
    localparam int unsigned LCR_EPS     = 4;
    localparam int unsigned LCR_STICK   = 5;

    typedef struct packed {
        logic       stick;
        logic       eps;
        logic       pen;
        logic [1:0] wls;
    } lcr_t;

    function automatic lcr_t lcr_decode(input logic [7:0] lcr);
        lcr_t f;
        f.wls   = lcr[LCR_WLS_LSB +: 2];
        f.pen   = lcr[LCR_PEN];
        f.eps   = lcr[LCR_EPS];
        f.stick = lcr[LCR_STICK];
        return f;
    endfunction

    // Parity bit a correct frame carries; unused upper data bits are zero.
    function automatic logic parity_expected(input logic [7:0] d, input lcr_t f);
        if (f.stick) return ~f.eps;
        if (f.eps)   return ^d;
        return ~^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: 16 x {bi,fe,pe,data[7:0]} with a registered head output.
module uart_rx_fifo
    import uart_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [FIFO_W-1:0] data_i,
    output logic [FIFO_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [FIFO_CW-1:0] count_o
);

    logic [FIFO_W-1:0]  mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_CW-1:0] count_q, count_d;
    logic [FIFO_W-1:0]  head_q;
    logic               do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FIFO_CW'(FIFO_DEPTH));
    assign count_o = count_q;
    assign data_o  = head_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Occupancy follows the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array, written on accepted push only.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers, count and the head register; the head holds while empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (count_q != '0) head_q <= mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled frame FSM feeding a 16-entry status FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SAMPLE_POINT = 7
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       RXD,
    input  logic [7:0] LCR,
    input  logic       enable,
    input  logic       rx_fifo_pop,
    output logic [7:0] rx_fifo_data,
    output logic       rx_pe,
    output logic       rx_fe,
    output logic       rx_bi,
    output logic       rx_fifo_empty,
    output logic       rx_fifo_full,
    output logic [4:0] rx_fifo_count,
    output logic       rx_overrun,
    output logic       busy
);

    uart_state_e  state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [2:0]   idx_q, idx_d;
    logic [7:0]   shift_q, shift_d;
    lcr_t         lcr_q, lcr_d;
    logic         par_bit_q, par_bit_d;
    logic         pe_q, pe_d;
    logic         rxd_meta_q, rxd_sync_q;
    logic         overrun_q;
    logic         push;
    logic [FIFO_W-1:0] push_data, head;
    logic         at_sample, at_end, rxd, fe, bi;
    logic         unused_lcr;

    assign unused_lcr = ^{LCR[7:6], LCR[2]};
    assign rxd        = rxd_sync_q;
    assign at_sample  = (cnt_q == 4'(SAMPLE_POINT));
    assign at_end     = (cnt_q == 4'hF);
    assign busy       = (state_q != IDLE);

    // Two-flop synchronizer for the asynchronous serial line, idles high.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= RXD;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    // Frame FSM state and datapath registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            lcr_q     <= '0;
            par_bit_q <= 1'b0;
            pe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            lcr_q     <= lcr_d;
            par_bit_q <= par_bit_d;
            pe_q      <= pe_d;
        end
    end

    // Next-state and push generation; everything advances only on enable.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        lcr_d     = lcr_q;
        par_bit_d = par_bit_q;
        pe_d      = pe_q;
        push      = 1'b0;
        fe        = !rxd;
        bi        = fe && (shift_q == '0) && !(lcr_q.pen && par_bit_q);
        push_data = {bi, fe, pe_q, shift_q};
        if (enable) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rxd) begin
                        state_d   = START;
                        cnt_d     = 4'd1;
                        idx_d     = '0;
                        shift_d   = '0;
                        lcr_d     = lcr_decode(LCR);
                        par_bit_d = 1'b0;
                        pe_d      = 1'b0;
                    end
                end
                START: begin
                    if (at_sample && rxd) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (at_end) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    if (at_sample) shift_d[idx_q] = rxd;
                    if (at_end) begin
                        if (idx_q == {1'b1, lcr_q.wls}) state_d = lcr_q.pen ? PARITY : STOP;
                        else                            idx_d   = idx_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (at_sample) begin
                        par_bit_d = rxd;
                        pe_d      = (rxd != parity_expected(shift_q, lcr_q));
                    end
                    if (at_end) state_d = STOP;
                end
                STOP: begin
                    if (at_sample) begin
                        push    = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Sticky overrun: set on a dropped push, cleared by any pop.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                                   overrun_q <= 1'b0;
        else if (push && rx_fifo_full && !rx_fifo_pop)  overrun_q <= 1'b1;
        else if (rx_fifo_pop)                           overrun_q <= 1'b0;
    end

    uart_rx_fifo u_fifo (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .push_i  (push),
        .pop_i   (rx_fifo_pop),
        .data_i  (push_data),
        .data_o  (head),
        .empty_o (rx_fifo_empty),
        .full_o  (rx_fifo_full),
        .count_o (rx_fifo_count)
    );

    assign rx_fifo_data = head[7:0];
    assign rx_pe        = head[8];
    assign rx_fe        = head[9];
    assign rx_bi        = head[10];
    assign rx_overrun   = overrun_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SAMPLE_POINT, default 7: oversample count (0..15) within each bit at which RXD is sampled.
REQ-002 SHALL have port PCLK  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port PRESETn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port RXD  in  1  serial input, asynchronous to PCLK, idle high.
REQ-005 SHALL have port LCR  in  8  line control: [1:0] word length 5/6/7/8, [3] parity enable, [4] even, [5] stick; [2] ignored (one stop bit checked).
REQ-006 SHALL have port enable  in  1  16x-baud strobe, one PCLK wide.
REQ-007 SHALL have port rx_fifo_pop  in  1  pop head entry.
REQ-008 SHALL have port rx_fifo_data  out  8  head data, upper unused bits zero.
REQ-009 SHALL have port rx_pe / rx_fe / rx_bi  out  1 each  parity, framing and break flags of the head entry.
REQ-010 SHALL have port rx_fifo_empty / rx_fifo_full  out  1 each  FIFO status.
REQ-011 SHALL have port rx_fifo_count  out  5  entries held, 0..16.
REQ-012 SHALL have port rx_overrun  out  1  sticky overrun flag.
REQ-013 SHALL have port busy  out  1  high while the FSM is not IDLE.

Function
REQ-014 SHALL pass RXD through a 2-flop synchronizer; all references to RXD below mean the synchronized value.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY and STOP, with a 4-bit oversample counter and a 3-bit bit index.
REQ-016 The 4-bit oversample counter SHALL advance only on enable and wrap 15->0.
REQ-017 IDLE: on enable with RXD=0, SHALL go to START with counter=1.
REQ-018 START: at counter==SAMPLE_POINT, RXD=1 SHALL be treated as a false start (return to IDLE, nothing pushed); otherwise, at counter==15 on enable, SHALL go to DATA with bit index 0.
REQ-019 DATA: SHALL sample RXD at SAMPLE_POINT into shift[index] (LSB first).
REQ-020 DATA: at counter==15 SHALL advance the index; after bit (4+LCR[1:0]) SHALL go to PARITY if LCR[3]=1, else to STOP.
REQ-021 PARITY: SHALL sample at SAMPLE_POINT and compare against the expected bit for LCR[5:3]: 001 -> odd (~^data), 011 -> even (^data), 101 -> 1, 111 -> 0; the data used SHALL be the received bits only.
REQ-022 PARITY: a mismatch SHALL set pe; the FSM SHALL go to STOP at counter==15.
REQ-023 STOP: SHALL sample at SAMPLE_POINT; fe = (RXD==0).
REQ-024 STOP: bi SHALL be set when fe=1, all data bits are 0 and the parity bit, if present, is 0.
REQ-025 STOP: SHALL push {bi,fe,pe,data} on the same cycle and return to IDLE on that cycle; remaining stop time is idle time.
REQ-026 SHALL keep LCR stable per frame; the value sampled at START entry SHALL be used.
REQ-027 A push while full with no simultaneous pop SHALL drop the frame and set rx_overrun.
REQ-028 rx_overrun SHALL clear on the next rx_fifo_pop.
REQ-029 Push and pop in the same cycle SHALL both take effect, count unchanged; when full, this SHALL NOT count as overrun.
REQ-030 Pop when empty SHALL be ignored, with outputs unchanged.
REQ-031 rx_fifo_data and the flags SHALL present the head entry one PCLK after it becomes head (push into empty, or pop).
REQ-032 With enable held low, the FSM and counter SHALL freeze.

Reset
REQ-033 PRESETn low SHALL asynchronously force: FSM IDLE, counter 0, index 0, synchronizer 1s, FIFO count 0, rx_fifo_empty=1, rx_fifo_full=0, rx_fifo_data=0, rx_pe=rx_fe=rx_bi=0, rx_overrun=0, busy=0.
REQ-034 Reset mid-frame SHALL discard the partial frame; after release, reception SHALL restart only on a new falling edge.

Structure
REQ-035 The state enum, FIFO depth 16 and the LCR field positions SHALL live in a shared uart package, also used by the transmitter.
REQ-036 SHALL instantiate one sub-module, uart_rx_fifo: 16 x 11-bit, with push, pop, data, empty, full and count.

Verification
REQ-037 8N1 (LCR=0x03), serial frame 0xA5 -> after stop sample, count=1, rx_fifo_data=0xA5, pe/fe/bi=0.
REQ-038 7E1 (LCR=0x1A), 0x35 sent with parity bit 1 -> data=0x35, rx_pe=1; with parity bit 0 -> rx_pe=0.
REQ-039 RXD low for 4 enables then high -> no push, busy returns to 0, a following 0x5A frame is received correctly.
REQ-040 Stop bit driven 0 on 0x00 -> rx_fe=1, rx_bi=1; on 0x81 -> rx_fe=1, rx_bi=0.
REQ-041 17 frames with no pops -> count=16, full=1, rx_overrun=1, 17th frame lost; one pop -> overrun=0, count=15.
REQ-042 PRESETn asserted during BIT3 of 0xFF -> all outputs at reset values immediately; next 0x11 frame received intact.
